rr_bus_arbiter8: RTL and testbench

Round-robin arbiter that shares a single 16-bit output bus between 8 requesters. It owns the select for an 8-way 16-bit mux (MUX8WAY16) and the one-hot grant fan-out (DMUX8WAY-style) that feeds it. It moves each requester's word to one downstream sink using a valid/ready handshake. Optional per-requester lock lets one requester send a bounded burst of back-to-back words.

---
 rtl/rr_bus_arbiter8_pkg.sv | 7 +
 rtl/rr_bus_arbiter8_if.sv | 14 +
 rtl/MUX8WAY16.sv | 16 +
 rtl/rr_bus_arbiter8_pick8.sv | 24 ++
 rtl/rr_bus_arbiter8.sv | 76 +++++++
 tb/tb_rr_bus_arbiter8.sv | 109 ++++++++++
 6 files changed

// File: rtl/rr_bus_arbiter8_pkg.sv
// rr_bus_arbiter8_pkg: shared sizes and FSM state encoding for the round-robin bus arbiter
package rr_bus_arbiter8_pkg;
    localparam int NUM_REQ = 8;
    localparam int DATA_W  = 16;
    localparam int ID_W    = 3;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/rr_bus_arbiter8_if.sv
// rr_bus_arbiter8_if: requester/sink handshake bundle between the requesters and the arbiter
interface rr_bus_arbiter8_if;
    import rr_bus_arbiter8_pkg::*;
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ-1:0]        LOCK;
    logic [NUM_REQ*DATA_W-1:0] DIN;
    logic                      READY;
    logic [DATA_W-1:0]         OUT;
    logic                      OUT_VALID;
    logic [NUM_REQ-1:0]        GNT;
    logic [ID_W-1:0]           GNT_ID;
    modport slave  (input REQ, LOCK, DIN, READY, output OUT, OUT_VALID, GNT, GNT_ID);
    modport master (output REQ, LOCK, DIN, READY, input OUT, OUT_VALID, GNT, GNT_ID);
endinterface

// File: rtl/MUX8WAY16.sv
// MUX8WAY16: 8-way 16-bit multiplexer selected by a 3-bit index
module MUX8WAY16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    assign out = sel[2] ? (sel[1] ? (sel[0] ? h : g) : (sel[0] ? f : e))
                        : (sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a));
endmodule

// File: rtl/rr_bus_arbiter8_pick8.sv
// rr_pick8: combinational rotating-priority picker; first unmasked request at or after the pointer
module rr_pick8
    import rr_bus_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_excl,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner
);
    logic [NUM_REQ-1:0] w_cand;
    logic [ID_W-1:0]    w_idx;
    assign w_cand = i_req & ~i_excl;
    assign o_any  = |w_cand;
    // scan farthest-to-nearest so the candidate closest to the pointer is the last one written
    always_comb begin
        o_winner = i_ptr;
        w_idx    = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + ID_W'(k);
            if (w_cand[w_idx]) o_winner = w_idx;
        end
    end
endmodule

// File: rtl/rr_bus_arbiter8.sv
// rr_bus_arbiter8: round-robin arbiter sharing one 16-bit valid/ready bus among 8 requesters with bounded lock bursts
module rr_bus_arbiter8
    import rr_bus_arbiter8_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input logic             clk,
    input logic             reset,
    rr_bus_arbiter8_if.slave bus
);
    localparam logic [3:0] LP_MAX = 4'(MAX_BURST);
    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_gnt_id;
    logic [3:0]          r_beats;
    logic                w_busy;
    logic                w_xfer;
    logic                w_keep;
    logic                w_rearb;
    logic                w_any;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_next_ptr;
    logic [ID_W-1:0]     w_pick_ptr;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [3:0]          w_beats_inc;
    logic [DATA_W-1:0]   w_mux;
    assign w_busy      = r_state == BUSY;
    assign w_gnt       = w_busy ? NUM_REQ'(1) << r_gnt_id : '0;
    assign w_next_ptr  = r_gnt_id + ID_W'(1);
    assign w_pick_ptr  = w_busy ? w_next_ptr : r_ptr;
    assign w_xfer      = w_busy & bus.READY;
    assign w_beats_inc = r_beats + 4'd1;
    assign w_keep      = bus.LOCK[r_gnt_id] & bus.REQ[r_gnt_id] & (w_beats_inc < LP_MAX);
    // release after a non-kept beat, or abort when the owner withdraws before transferring
    assign w_rearb     = w_busy & (w_xfer ? !w_keep : !bus.REQ[r_gnt_id]);
    // while busy the current owner is masked out so release hands over without a bubble
    rr_pick8 u_pick (
        .i_req    (bus.REQ),
        .i_excl   (w_gnt),
        .i_ptr    (w_pick_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );
    MUX8WAY16 u_mux (
        .a   (bus.DIN[0*DATA_W +: DATA_W]),
        .b   (bus.DIN[1*DATA_W +: DATA_W]),
        .c   (bus.DIN[2*DATA_W +: DATA_W]),
        .d   (bus.DIN[3*DATA_W +: DATA_W]),
        .e   (bus.DIN[4*DATA_W +: DATA_W]),
        .f   (bus.DIN[5*DATA_W +: DATA_W]),
        .g   (bus.DIN[6*DATA_W +: DATA_W]),
        .h   (bus.DIN[7*DATA_W +: DATA_W]),
        .sel (r_gnt_id),
        .out (w_mux)
    );
    // grant FSM: arbitrate from idle, extend a locked burst, or rotate on release/abort
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt_id <= '0;
            r_beats  <= '0;
        end else if (w_xfer && w_keep) begin
            r_beats <= w_beats_inc;
        end else if (!w_busy || w_rearb) begin
            if (w_busy) r_ptr <= w_next_ptr;
            if (w_any) r_gnt_id <= w_winner;
            r_state <= w_any ? BUSY : IDLE;
            r_beats <= '0;
        end
    end
    assign bus.OUT_VALID = w_busy;
    assign bus.GNT       = w_gnt;
    assign bus.GNT_ID    = r_gnt_id;
    assign bus.OUT       = w_busy ? w_mux : '0;
endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// tb_rr_bus_arbiter8: directed vector table plus hand sequences for the round-robin bus arbiter
module tb_rr_bus_arbiter8;
    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] lock;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_id;
        int         exp_ptr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    logic [15:0] dv [8] = '{16'h1111, 16'hA1A1, 16'h2222, 16'hBEEF,
                            16'h4444, 16'h5555, 16'h6666, 16'h7777};
    vec_t tv[$];

    rr_bus_arbiter8_if bus();
    rr_bus_arbiter8 #(.MAX_BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic vec_t v(logic rst, logic [7:0] req, logic [7:0] lock, logic ready,
                               logic ev, logic [2:0] eid, int eptr);
        vec_t r;
        r.rst = rst; r.req = req; r.lock = lock; r.ready = ready;
        r.exp_valid = ev; r.exp_id = eid; r.exp_ptr = eptr;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic rst, logic [7:0] req, logic [7:0] lock, logic ready);
        reset = rst;
        bus.REQ = req;
        bus.LOCK = lock;
        bus.READY = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string tag, logic ev, logic [2:0] eid);
        logic [7:0] eg;
        logic [15:0] eo;
        eg = ev ? 8'b1 << eid : 8'h00;
        eo = ev ? dv[eid] : 16'h0000;
        chk({tag, " valid"}, 32'(bus.OUT_VALID), 32'(ev));
        chk({tag, " gnt_id"}, 32'(bus.GNT_ID), 32'(eid));
        chk({tag, " gnt"}, 32'(bus.GNT), 32'(eg));
        chk({tag, " out"}, 32'(bus.OUT), 32'(eo));
    endtask

    initial begin
        reset = 1'b1;
        bus.REQ = '0;
        bus.LOCK = '0;
        bus.READY = 1'b0;
        for (int i = 0; i < 8; i++) bus.DIN[16*i +: 16] = dv[i];
        // rotation between 0 and 2 with no bubble
        tv.push_back(v(1, 8'h00, 8'h00, 0, 0, 3'd0, 0));
        tv.push_back(v(0, 8'h05, 8'h00, 1, 1, 3'd0, -1));
        tv.push_back(v(0, 8'h05, 8'h00, 1, 1, 3'd2, -1));
        tv.push_back(v(0, 8'h05, 8'h00, 1, 1, 3'd0, -1));
        tv.push_back(v(0, 8'h00, 8'h00, 1, 0, 3'd0, 1));
        // backpressure: six valid cycles, single transfer on the sixth
        for (int i = 0; i < 6; i++) tv.push_back(v(0, 8'h08, 8'h00, 0, 1, 3'd3, -1));
        tv.push_back(v(0, 8'h08, 8'h00, 1, 0, 3'd3, 4));
        // locked burst of four beats, then forced release to 5
        tv.push_back(v(1, 8'h00, 8'h00, 0, 0, 3'd0, 0));
        for (int i = 0; i < 4; i++) tv.push_back(v(0, 8'h22, 8'h02, 1, 1, 3'd1, -1));
        tv.push_back(v(0, 8'h22, 8'h02, 1, 1, 3'd5, 2));
        // abort: 6 withdraws under backpressure, 7 takes over
        tv.push_back(v(0, 8'h20, 8'h00, 1, 0, 3'd5, 6));
        tv.push_back(v(0, 8'h40, 8'h00, 0, 1, 3'd6, -1));
        tv.push_back(v(0, 8'h80, 8'h00, 0, 1, 3'd7, 7));
        tv.push_back(v(0, 8'h80, 8'h00, 1, 0, 3'd7, 0));
        // all requesting: full rotation, one beat each
        for (int i = 0; i < 9; i++) tv.push_back(v(0, 8'hFF, 8'h00, 1, 1, 3'(i), -1));
        // reset while busy, then fresh grant
        tv.push_back(v(1, 8'hFF, 8'h00, 1, 0, 3'd0, 0));
        tv.push_back(v(0, 8'h80, 8'h00, 1, 1, 3'd7, 0));
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].req, tv[i].lock, tv[i].ready);
            chk_out($sformatf("v%0d", i), tv[i].exp_valid, tv[i].exp_id);
            if (tv[i].exp_ptr >= 0) chk($sformatf("v%0d ptr", i), 32'(dut.r_ptr), 32'(tv[i].exp_ptr));
        end
        // sole unlocked requester: released, idles one cycle, re-granted
        for (int k = 0; k < 6; k++) begin
            step(0, 8'h01, 8'h00, 1);
            chk_out($sformatf("solo%0d", k), k % 2 == 0, 3'd0);
        end
        // sole locked requester: four beats, forced release bubble, re-grant
        for (int k = 0; k < 6; k++) begin
            step(0, 8'h01, 8'h01, 1);
            chk_out($sformatf("lock%0d", k), k != 4, 3'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
